// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter and instruction-fetch stage of the MIPS core. Holds the PC,
//   requests instructions from instruction memory, latches the fetched word for
//   decode and computes the next PC (PC+4, branch, J-type, JR).
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned next PC (only JR can produce one) sets the sticky
//               misalign_err flag and parks the unit in HALT until reset.
//   undefined : the low two bits of the next PC are cleared and fetch goes on;
//               misalign_err is tied to 0.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   imem_req/addr        fetch request and address (address = pc_out)
//   imem_ready/rdata     memory handshake and returned instruction word
//   instr_out/valid      instruction presented to decode
//   pc_out, pc_plus4     PC of instr_out and PC+4 (combinational)
//   stall                decode not ready, hold the current instruction
//   branch_taken, sign_ext_imm   conditional branch redirect (word offset)
//   jump, jump_target    J/JAL redirect
//   jr, jr_addr          JR redirect
//   retired_cnt          instructions accepted by decode (wraps)
//   misalign_err         sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      sign_ext_imm,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [31:0]        instr_reg, instr_next;
  logic               valid_reg, valid_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [31:0]        branch_addr;
  logic [31:0]        jump_addr;
  logic [31:0]        sel_pc;

  assign pc_plus4    = pc_reg + 32'd4;
  // Branch offset is in words; the shift drops the top two immediate bits.
  assign branch_addr = pc_plus4 + {sign_ext_imm[29:0], 2'b00};
  assign jump_addr   = {pc_plus4[31:28], jump_target, 2'b00};

  // Redirect priority: JR, then J, then taken branch, then sequential.
  always_comb begin
    sel_pc = pc_plus4;
    if (jr)
      sel_pc = jr_addr;
    else if (jump)
      sel_pc = jump_addr;
    else if (branch_taken)
      sel_pc = branch_addr;
  end

  assign imem_req    = (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign instr_out   = instr_reg;
  assign instr_valid = valid_reg;
  assign pc_out      = pc_reg;
  assign retired_cnt = cnt_reg;

`ifdef PC_MISALIGN_TRAP_EN
  logic err_reg, err_next;
  assign misalign_err = err_reg;
`else
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    cnt_next   = cnt_reg;
`ifdef PC_MISALIGN_TRAP_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // While stalled everything, including redirects, is ignored.
        if (!stall) begin
          cnt_next = cnt_reg + CNT_W'(1);
`ifdef PC_MISALIGN_TRAP_EN
          if (sel_pc[1:0] != 2'b00) begin
            // Keep the faulting PC and instruction visible for debug.
            err_next   = 1'b1;
            state_next = HALT;
          end else begin
            pc_next    = sel_pc;
            valid_next = 1'b0;
            state_next = FETCH;
          end
`else
          pc_next    = sel_pc & ~32'h3;
          valid_next = 1'b0;
          state_next = FETCH;
`endif
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
`ifdef PC_MISALIGN_TRAP_EN
      err_reg   <= err_next;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed self-checking bench for pc_fetch_unit (RESET_PC = 0, CNT_W = 32).
//   Instruction memory returns addr ^ MEM_KEY so every fetched word is known.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] MEM_KEY = 32'h8C00_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [31:0] sign_ext_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] retired_cnt;
  logic        misalign_err;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_ret      = 32'h0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ MEM_KEY;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .branch_taken (branch_taken),
    .sign_ext_imm (sign_ext_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .retired_cnt  (retired_cnt),
    .misalign_err (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    jr           = 1'b0;
    jr_addr      = 32'h0;
    jump         = 1'b0;
    jump_target  = 26'h0;
    branch_taken = 1'b0;
    sign_ext_imm = 32'h0;
  endtask

  // From FETCH at exp_pc with memory ready: one edge later the word is in ISSUE.
  task automatic do_fetch(input logic [31:0] exp_pc);
    check_eq("fetch_req", {31'h0, imem_req}, 32'h1);
    check_eq("fetch_addr", imem_addr, exp_pc);
    imem_ready = 1'b1;
    tick();
    check_eq("issue_valid", {31'h0, instr_valid}, 32'h1);
    check_eq("issue_instr", instr_out, exp_pc ^ MEM_KEY);
    check_eq("issue_pc", pc_out, exp_pc);
    check_eq("issue_pc_plus4", pc_plus4, exp_pc + 32'd4);
    check_eq("issue_req", {31'h0, imem_req}, 32'h0);
    $display("[TB] fetch  pc=0x%08h instr=0x%08h", pc_out, instr_out);
  endtask

  // From ISSUE: accept with the given redirects, expect FETCH at exp_next.
  task automatic do_accept(input logic j_r, input logic [31:0] j_addr, input logic jmp,
                           input logic [25:0] tgt, input logic br, input logic [31:0] imm,
                           input logic [31:0] exp_next);
    jr = j_r; jr_addr = j_addr; jump = jmp; jump_target = tgt;
    branch_taken = br; sign_ext_imm = imm; stall = 1'b0;
    tick();
    clear_redirects();
    exp_ret = exp_ret + 32'd1;
    check_eq("accept_retired", retired_cnt, exp_ret);
    check_eq("accept_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("accept_next_addr", imem_addr, exp_next);
    check_eq("accept_req", {31'h0, imem_req}, 32'h1);
    check_eq("accept_misalign", {31'h0, misalign_err}, 32'h0);
    $display("[TB] accept next=0x%08h retired=%0d", imem_addr, retired_cnt);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    clear_redirects();
    tick(); tick();
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_instr", instr_out, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_retired", retired_cnt, 32'h0);
    check_eq("rst_misalign", {31'h0, misalign_err}, 32'h0);
    $display("[TB] reset  pc=0x%08h valid=%0d", pc_out, instr_valid);

    rst_n = 1'b1;
    tick();  // IDLE -> FETCH

    // Sequential fetch 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      do_fetch(32'(4 * k));
      do_accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'(4 * k + 4));
    end
    check_eq("seq_retired3", retired_cnt, 32'd3);

    // Branches from 0x100: backward by 2 words, forward by 3 words
    do_fetch(32'hC);
    do_accept(1'b1, 32'h100, 1'b0, 26'h0, 1'b0, 32'h0, 32'h100);
    do_fetch(32'h100);
    do_accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE, 32'h0FC);
    do_fetch(32'h0FC);
    do_accept(1'b1, 32'h100, 1'b0, 26'h0, 1'b0, 32'h0, 32'h100);
    do_fetch(32'h100);
    do_accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0003, 32'h110);

    // Redirect priority from 0x4000_0010
    do_fetch(32'h110);
    do_accept(1'b1, 32'h4000_0010, 1'b0, 26'h0, 1'b0, 32'h0, 32'h4000_0010);
    do_fetch(32'h4000_0010);
    do_accept(1'b1, 32'h200, 1'b1, 26'h10, 1'b1, 32'h5, 32'h200);
    do_fetch(32'h200);
    do_accept(1'b1, 32'h4000_0010, 1'b0, 26'h0, 1'b0, 32'h0, 32'h4000_0010);
    do_fetch(32'h4000_0010);
    do_accept(1'b0, 32'h0, 1'b1, 26'h10, 1'b1, 32'h5, 32'h4000_0040);

    // Stall in ISSUE for 3 cycles with redirects wiggling
    do_fetch(32'h4000_0040);
    stall = 1'b1; jr_addr = 32'h300; jump_target = 26'h3;
    for (int c = 0; c < 3; c++) begin
      branch_taken = ~branch_taken; jr = (c == 1); jump = (c == 2);
      sign_ext_imm = 32'h40;
      tick();
      check_eq("stall_instr", instr_out, 32'h4000_0040 ^ MEM_KEY);
      check_eq("stall_pc", pc_out, 32'h4000_0040);
      check_eq("stall_retired", retired_cnt, exp_ret);
      check_eq("stall_valid", {31'h0, instr_valid}, 32'h1);
      check_eq("stall_req", {31'h0, imem_req}, 32'h0);
      $display("[TB] stall  cycle=%0d pc=0x%08h retired=%0d", c, pc_out, retired_cnt);
    end
    do_accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h4000_0044);

    // pc_plus4 wrap-around at the top of the address space
    do_fetch(32'h4000_0044);
    do_accept(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC);
    do_accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0);

    // Memory not ready: request held, address stable, then reset mid-fetch
    do_fetch(32'h0);
    do_accept(1'b1, 32'h80, 1'b0, 26'h0, 1'b0, 32'h0, 32'h80);
    imem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("wait_req", {31'h0, imem_req}, 32'h1);
      check_eq("wait_addr", imem_addr, 32'h80);
      check_eq("wait_valid", {31'h0, instr_valid}, 32'h0);
      $display("[TB] wait   cycle=%0d addr=0x%08h", c, imem_addr);
    end
    rst_n = 1'b0; imem_ready = 1'b1;  // ready in the reset cycle must be ignored
    tick();
    check_eq("midrst_pc", pc_out, 32'h0);
    check_eq("midrst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("midrst_instr", instr_out, 32'h0);
    check_eq("midrst_req", {31'h0, imem_req}, 32'h0);
    check_eq("midrst_retired", retired_cnt, 32'h0);
    $display("[TB] midrst pc=0x%08h valid=%0d", pc_out, instr_valid);
    exp_ret = 32'h0;
    rst_n = 1'b1;
    tick();

    // Misaligned JR target
    do_fetch(32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    jr = 1'b1; jr_addr = 32'h202;
    tick();
    clear_redirects();
    exp_ret = exp_ret + 32'd1;
    check_eq("trap_retired", retired_cnt, exp_ret);
    check_eq("trap_pc", pc_out, 32'h0);
    for (int c = 0; c < 4; c++) begin
      check_eq("trap_misalign", {31'h0, misalign_err}, 32'h1);
      check_eq("trap_req", {31'h0, imem_req}, 32'h0);
      check_eq("trap_pc_hold", pc_out, 32'h0);
      $display("[TB] halt   cycle=%0d err=%0d req=%0d", c, misalign_err, imem_req);
      tick();
    end
`else
    do_accept(1'b1, 32'h202, 1'b0, 26'h0, 1'b0, 32'h0, 32'h200);
    check_eq("noatrap_misalign", {31'h0, misalign_err}, 32'h0);
    do_fetch(32'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the MIPS core.
- Holds the PC, requests instructions from instruction memory, and presents the fetched word to decode.
- Computes the next PC from PC+4, the branch offset (32-bit sign-extended immediate from the sign-extension stage), J-type targets and JR register targets.
- Downstream consumer of the sign-extended immediate; upstream of decode/register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (equals pc_out while imem_req=1)
imem_ready  input  1  instruction memory has imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr_out  output  32  latched instruction for decode
instr_valid  output  1  instr_out holds a valid instruction
pc_out  output  32  PC of instr_out
pc_plus4  output  32  pc_out + 4, modulo 2^32
stall  input  1  decode not ready; hold current instruction
branch_taken  input  1  conditional branch resolved taken
sign_ext_imm  input  32  sign-extended 16-bit immediate (branch offset in words)
jump  input  1  J/JAL redirect
jump_target  input  26  instr_index field of J-type
jr  input  1  JR redirect
jr_addr  input  32  register value for JR
retired_cnt  output  CNT_W  count of instructions accepted by decode
misalign_err  output  1  sticky misaligned-target flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc_out=RESET_PC; instr_out=0; instr_valid=0; imem_req=0.
  - retired_cnt=0; misalign_err=0; state=IDLE.
  - Reset wins over every other input, in any state including mid-fetch. An in-flight imem_ready in the reset cycle is ignored.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: one cycle with imem_req=0, then go to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc_out, combinationally from state.
  - If imem_ready=1: latch instr_out=imem_rdata, set instr_valid=1, go to ISSUE.
  - Otherwise stay in FETCH with the request held and the address stable. There is no timeout.
- ISSUE:
  - imem_req=0; instr_valid=1.
  - If stall=1: hold everything. Redirect inputs are ignored while stalled.
  - If stall=0: the instruction is accepted. retired_cnt increments by 1, wrapping at 2^CNT_W. PC is updated, instr_valid goes to 0 on the next edge, and state goes to FETCH.
- Next-PC priority, evaluated only in ISSUE with stall=0:
  - jr: jr_addr
  - else jump: {pc_plus4[31:28], jump_target, 2'b00}
  - else branch_taken: pc_plus4 + (sign_ext_imm << 2), 32-bit, modulo 2^32
  - else: pc_plus4
- Simultaneous redirects resolve by that priority; the other inputs are ignored.
- Fetch latency: at least 1 cycle from FETCH entry with imem_ready already high. The minimum instruction period is 2 cycles (FETCH, ISSUE).
- pc_plus4 is combinational from pc_out. Wrap-around case: pc_out=32'hFFFF_FFFC gives pc_plus4=32'h0.
- HALT is reachable only with the optional feature. Outputs are frozen, imem_req=0, and only reset exits.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN
- Defined:
  - In ISSUE with stall=0, if the selected next PC has bits [1:0]≠0 (only JR can produce this), set misalign_err=1 (sticky) and go to HALT.
  - pc_out keeps the faulting instruction's PC.
  - retired_cnt still increments for that instruction.
- Undefined:
  - No check. The low two bits of the next PC are forced to 2'b00 and fetch continues.
  - misalign_err is tied to 0.

Test Plan:
1. Reset with RESET_PC=0, imem_ready=1 constantly, no redirects, stall=0:
   - imem_addr sequence is 0x0, 0x4, 0x8, one fetch every 2 cycles.
   - retired_cnt reaches 3 after the third ISSUE.
2. pc_out=0x100, branch_taken=1, sign_ext_imm=32'hFFFF_FFFE:
   - next imem_addr=0x104-8=0x0FC.
   - With sign_ext_imm=32'h0000_0003: next imem_addr=0x110.
3. pc_out=0x4000_0010, jump=1, jr=1, jr_addr=0x200, branch_taken=1 in the same cycle:
   - next PC=0x200 (JR wins).
   - Repeat with jr=0 and jump_target=26'h10: next PC=0x4000_0040.
4. stall=1 held 3 cycles in ISSUE, with branch_taken toggling meanwhile:
   - instr_out, pc_out and retired_cnt are unchanged.
   - After stall drops with no redirect, next PC=pc_plus4.
5. imem_ready held low 4 cycles in FETCH:
   - imem_req=1 and imem_addr stable throughout.
   - rst_n pulsed low in cycle 3 returns pc_out to RESET_PC and instr_valid to 0 on the next edge.
6. PC_MISALIGN_TRAP_EN defined, jr=1, jr_addr=0x202:
   - misalign_err=1, imem_req stays 0 indefinitely.
   - Without the macro: next imem_addr=0x200, misalign_err=0.
